// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED flash arbiter: FSM state encoding and default field width.
package led_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam int COUNT_W_DEF = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping around.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [OW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [OW-1:0]    winner,
   output logic             valid
);

   logic [OW-1:0] idx;

   always_comb begin
      grant  = '0;
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = OW'((int'(ptr) + i) % N_REQ);
         if (!valid && req[idx]) begin
            valid       = 1'b1;
            grant[idx]  = 1'b1;
            winner      = idx;
         end
      end
   end

endmodule

// File: rtl/led_flash_arbiter.sv
// Shares one LED among N_REQ requesters: round-robin grant, N-blink playback, idle gap between owners.
//   state  | meaning
//   S_IDLE | waiting for any request
//   S_ON   | LED lit for one half-period
//   S_OFF  | LED dark for one half-period
//   S_GAP  | LED dark, separation before the next owner
module led_flash_arbiter
   import led_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int HALF_PERIOD = 50_000_000,
   parameter int COUNT_W     = COUNT_W_DEF,
   parameter int OW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*COUNT_W-1:0]   count,
   output logic [N_REQ-1:0]           ack,
   output logic [N_REQ-1:0]           done,
   output logic [OW-1:0]              owner,
   output logic                       busy,
   output logic                       led
);

   localparam int TW = $clog2(2 * HALF_PERIOD);
   localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_PERIOD - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(2 * HALF_PERIOD - 1);

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [COUNT_W-1:0]   rem_q, rem_d;
   logic [OW-1:0]        ptr_q, ptr_d;
   logic [OW-1:0]        owner_q, owner_d;
   logic [N_REQ-1:0]     ack_q, ack_d;
   logic [N_REQ-1:0]     done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 led_q, led_d;

   logic [N_REQ-1:0]     grant;
   logic [OW-1:0]        winner;
   logic                 any_req;
   logic [COUNT_W-1:0]   cnt_sel;

   rr_arbiter #(.N_REQ(N_REQ), .OW(OW)) u_rr (
      .req    (req),
      .ptr    (ptr_q),
      .grant  (grant),
      .winner (winner),
      .valid  (any_req)
   );

   assign cnt_sel = count[int'(winner)*COUNT_W +: COUNT_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         rem_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rem_q   <= rem_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rem_d   = rem_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      ack_d   = '0;
      done_d  = '0;
      busy_d  = busy_q;
      led_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               ack_d   = grant;
               owner_d = winner;
               busy_d  = 1'b1;
               rem_d   = cnt_sel;
               ptr_d   = (winner == OW'(N_REQ - 1)) ? '0 : winner + OW'(1);
               if (cnt_sel != '0) begin
                  state_d = S_ON;
                  timer_d = HALF_LOAD;
                  led_d   = 1'b1;
               end else begin
                  // Zero-blink request completes immediately but still pays the gap.
                  state_d = S_GAP;
                  timer_d = GAP_LOAD;
                  done_d  = grant;
               end
            end
         end
         S_ON: begin
            if (timer_q == '0) begin
               state_d = S_OFF;
               timer_d = HALF_LOAD;
            end else begin
               timer_d = timer_q - TW'(1);
               led_d   = 1'b1;
            end
         end
         S_OFF: begin
            if (timer_q == '0) begin
               rem_d = rem_q - COUNT_W'(1);
               if (rem_q != COUNT_W'(1)) begin
                  state_d = S_ON;
                  timer_d = HALF_LOAD;
                  led_d   = 1'b1;
               end else begin
                  state_d = S_GAP;
                  timer_d = GAP_LOAD;
                  done_d  = N_REQ'(1) << owner_q;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_GAP: begin
            if (timer_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ack   = ack_q;
   assign done  = done_q;
   assign owner = owner_q;
   assign busy  = busy_q;
   assign led   = led_q;

endmodule

// File: doc/led_flash_arbiter.md
# led_flash_arbiter

Shares the board's single user LED (LED1) among several requesters. Each requester asks for an N-blink flash sequence. The block grants requests round-robin, plays the blinks with a fixed on/off half-period, and enforces an idle gap between owners. It sits between the top-level status sources and the LED pin, so on-board diagnostics from several subsystems stay distinguishable.

## Interface
- N_REQ, 4, number of requesters (2..8)
- HALF_PERIOD, 50_000_000, clock cycles per LED on phase and per off phase (≥2)
- COUNT_W, 4, width of each blink-count field
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  level request, one bit per requester
- count  in  N_REQ*COUNT_W  packed blink counts; field i = count[i*COUNT_W +: COUNT_W]
- ack  out  N_REQ  one-cycle pulse: request i accepted, its count latched
- done  out  N_REQ  one-cycle pulse: sequence for requester i finished
- owner  out  max(1,$clog2(N_REQ))  index of the current or last granted requester
- busy  out  1  high from grant until the gap ends
- led  out  1  LED drive, active-high

## Operation
- Reset values: led=0, busy=0, ack=0, done=0, owner=0, state=IDLE, rr pointer=0, timer=0, remaining=0.
- Reset asserted mid-sequence aborts immediately. No done is issued for the aborted owner.
- States:
  - IDLE: wait for any req.
  - ON: led=1.
  - OFF: led=0.
  - GAP: led=0, separation between owners.
- IDLE, any req set at an edge:
  - Winner = first set bit searching from pointer upward with wrap.
  - ack[winner]=1 for one cycle; owner=winner; busy=1; remaining=count field; pointer=winner+1 mod N_REQ.
  - If count field ≠ 0: go to ON, timer=HALF_PERIOD-1.
  - If count field = 0: done[winner] pulses in the same cycle as ack, go to GAP, LED never lights.
- ON → OFF when timer=0; timer reloads HALF_PERIOD-1.
- OFF, timer=0:
  - remaining-1 ≠ 0: go to ON.
  - Otherwise: go to GAP, timer=2*HALF_PERIOD-1, done[owner]=1 for one cycle.
  - remaining decrements on every OFF exit.
- GAP → IDLE when timer=0; busy falls on that edge.
- Count fields are sampled only at the grant edge. Later changes are ignored.
- req is not sampled outside IDLE. A requester that keeps req high after its ack is treated as a new request at the next IDLE arbitration.
- Timer width is $clog2(2*HALF_PERIOD). remaining width is COUNT_W. No overflow is possible by construction.

## Timing
- Grant latency: 1 cycle. req seen at an edge in IDLE gives ack, busy and led on that edge's outputs.
- ack edge to done edge = 2*HALF_PERIOD*count cycles, for count ≥ 1.
- done edge to busy low = 2*HALF_PERIOD cycles. Earliest next ack is the edge after busy falls.
- All outputs are registered. ack, done and led change only on clk edges, except under asynchronous reset.
- Simultaneous requests: exactly one ack per grant, and never two ack bits set in the same cycle.

## Structure
- Package led_arb_pkg holds:
  - state encoding localparams S_IDLE, S_ON, S_OFF, S_GAP (2 bits);
  - the default COUNT_W.
- Sub-module rr_arbiter (combinational): inputs req and pointer, outputs a one-hot grant plus the winner index.
- The FSM, timer and remaining counter live in led_flash_arbiter.

## Test plan
All scenarios use N_REQ=4, HALF_PERIOD=4.
- Reset: assert rst for 3 cycles with req=4'b1111 → led=0, busy=0, ack=0, done=0, owner=0 throughout.
- Single request: req=4'b0100, count[11:8]=3 →
  - ack=4'b0100 for one cycle, owner=2;
  - led pattern 4 high / 4 low, repeated 3 times;
  - done=4'b0100 exactly 24 cycles after ack;
  - busy falls 8 cycles after done.
- Contention: req=4'b1111 held, all counts=1 → grants in order 0,1,2,3,0; consecutive acks 17 cycles apart (8 blink + 8 gap + 1 arbitration).
- Zero count: req=4'b0001, count[3:0]=0 → ack[0] and done[0] in the same cycle; led stays 0; busy high for 8 cycles.
- Reset mid-sequence: assert rst during the second ON phase of a count-5 sequence →
  - led drops asynchronously; no done pulse;
  - after release, req=4'b1010 grants requester 1 first (pointer back to 0).
- Late count change: alter the owner's count field after ack → blink count unchanged from the latched value.
